// File: rtl/mem_port_arbiter.sv
// Two-master round-robin arbiter for a single synchronous memory port.
// Bursts are capped at MAX_BURST cycles only while the other master is waiting.
module mem_port_arbiter #(
  parameter int N         = 32,
  parameter int AW        = 32,
  parameter int MAX_BURST = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req,
  input  logic [AW-1:0] m0_addr,
  input  logic          m0_wr_ena,
  input  logic [N-1:0]  m0_wr_data,
  output logic          m0_gnt,
  output logic          m0_rd_valid,
  input  logic          m1_req,
  input  logic [AW-1:0] m1_addr,
  input  logic          m1_wr_ena,
  input  logic [N-1:0]  m1_wr_data,
  output logic          m1_gnt,
  output logic          m1_rd_valid,
  output logic [N-1:0]  m_rd_data,
  output logic [AW-1:0] mem_addr,
  output logic [N-1:0]  mem_wr_data,
  output logic          mem_wr_ena,
  input  logic [N-1:0]  mem_rd_data
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_M0   = 2'd1,
    OWN_M1   = 2'd2
  } own_t;

  localparam logic [3:0] HOLD_LIM = 4'(MAX_BURST - 1);

  own_t       owner_p0;
  own_t       decision;
  logic       last_m1_p0;
  logic       last_m1_nxt;
  logic [3:0] burst_cnt_p0;
  logic [3:0] burst_cnt_nxt;
  logic       vld0_p1;
  logic       vld1_p1;

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  // State register: arbitration history plus the one-cycle read-return tags
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_p0     <= OWN_NONE;
      last_m1_p0   <= 1'b1;
      burst_cnt_p0 <= 4'd0;
      vld0_p1      <= 1'b0;
      vld1_p1      <= 1'b0;
    end else begin
      owner_p0     <= decision;
      last_m1_p0   <= last_m1_nxt;
      burst_cnt_p0 <= burst_cnt_nxt;
      vld0_p1      <= m0_gnt & ~m0_wr_ena;
      vld1_p1      <= m1_gnt & ~m1_wr_ena;
    end
  end

  // Next-state: same-cycle grant decision; the burst cap only bites under contention
  always_comb begin
    decision      = OWN_NONE;
    last_m1_nxt   = last_m1_p0;
    burst_cnt_nxt = 4'd0;
    if (rst) begin
      decision = OWN_NONE;
    end else if (owner_p0 == OWN_M0 && m0_req && (!m1_req || burst_cnt_p0 < HOLD_LIM)) begin
      decision = OWN_M0;
    end else if (owner_p0 == OWN_M1 && m1_req && (!m0_req || burst_cnt_p0 < HOLD_LIM)) begin
      decision = OWN_M1;
    end else if (m0_req && m1_req) begin
      decision = last_m1_p0 ? OWN_M0 : OWN_M1;
    end else if (m0_req) begin
      decision = OWN_M0;
    end else if (m1_req) begin
      decision = OWN_M1;
    end
    if (decision != OWN_NONE) begin
      last_m1_nxt = (decision == OWN_M1);
    end
    if (decision != OWN_NONE && decision == owner_p0) begin
      burst_cnt_nxt = sat_inc(burst_cnt_p0);
    end
  end

  // Outputs: grants, memory-port mux and read-data tagging
  always_comb begin
    m0_gnt      = (decision == OWN_M0);
    m1_gnt      = (decision == OWN_M1);
    mem_addr    = '0;
    mem_wr_data = '0;
    mem_wr_ena  = 1'b0;
    if (decision == OWN_M0) begin
      mem_addr    = m0_addr;
      mem_wr_data = m0_wr_data;
      mem_wr_ena  = m0_wr_ena;
    end else if (decision == OWN_M1) begin
      mem_addr    = m1_addr;
      mem_wr_data = m1_wr_data;
      mem_wr_ena  = m1_wr_ena;
    end
    m0_rd_valid = vld0_p1 & ~rst;
    m1_rd_valid = vld1_p1 & ~rst;
    m_rd_data   = mem_rd_data;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (MAX_BURST=4) with a one-cycle-latency memory model.
module tb_mem_port_arbiter;
  localparam int N  = 32;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          m0_req, m0_wr_ena, m0_gnt, m0_rd_valid;
  logic [AW-1:0] m0_addr;
  logic [N-1:0]  m0_wr_data;
  logic          m1_req, m1_wr_ena, m1_gnt, m1_rd_valid;
  logic [AW-1:0] m1_addr;
  logic [N-1:0]  m1_wr_data;
  logic [N-1:0]  m_rd_data, mem_wr_data, mem_rd_data;
  logic [AW-1:0] mem_addr;
  logic          mem_wr_ena;

  logic [N-1:0]  mem [0:63];

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.N(N), .AW(AW), .MAX_BURST(4)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_wr_ena(m0_wr_ena), .m0_wr_data(m0_wr_data),
    .m0_gnt(m0_gnt), .m0_rd_valid(m0_rd_valid),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_wr_ena(m1_wr_ena), .m1_wr_data(m1_wr_data),
    .m1_gnt(m1_gnt), .m1_rd_valid(m1_rd_valid),
    .m_rd_data(m_rd_data), .mem_addr(mem_addr), .mem_wr_data(mem_wr_data),
    .mem_wr_ena(mem_wr_ena), .mem_rd_data(mem_rd_data)
  );

  // Synchronous memory: read data appears one cycle after the address
  always @(posedge clk) begin
    if (mem_wr_ena) mem[mem_addr[7:2]] <= mem_wr_data;
    mem_rd_data <= mem[mem_addr[7:2]];
  end

  typedef struct {
    logic        rst;
    logic        r0;
    logic [31:0] a0;
    logic        r1;
    logic [31:0] a1;
    logic        w1;
    logic [31:0] d1;
    logic        g0;
    logic        g1;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wd;
    logic        rv0;
    logic        rv1;
    logic [31:0] rdata;
  } vec_t;

  vec_t vt [22];

  function automatic vec_t mk(input logic rs, input logic r0, input logic [31:0] a0,
                              input logic r1, input logic [31:0] a1, input logic w1,
                              input logic [31:0] d1, input logic g0, input logic g1,
                              input logic we, input logic [31:0] addr, input logic [31:0] wd,
                              input logic rv0, input logic rv1, input logic [31:0] rdata);
    vec_t v;
    v.rst = rs; v.r0 = r0; v.a0 = a0; v.r1 = r1; v.a1 = a1; v.w1 = w1; v.d1 = d1;
    v.g0 = g0; v.g1 = g1; v.we = we; v.addr = addr; v.wd = wd;
    v.rv0 = rv0; v.rv1 = rv1; v.rdata = rdata;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'hA000_0000 + i;
    mem[16] = 32'hDEAD_BEEF;

    //            rst r0 a0     r1 a1     w1 d1        g0 g1 we addr   wd       rv0 rv1 rdata
    vt[0]  = mk(1, 1, 32'h08, 1, 32'h40, 0, 32'h0,    0, 0, 0, 32'h0,  32'h0,    0, 0, 32'h0);
    vt[1]  = mk(1, 1, 32'h08, 1, 32'h40, 0, 32'h0,    0, 0, 0, 32'h0,  32'h0,    0, 0, 32'h0);
    vt[2]  = mk(0, 1, 32'h08, 1, 32'h40, 0, 32'h0,    1, 0, 0, 32'h08, 32'h5A5A, 0, 0, 32'h0);
    vt[3]  = mk(0, 1, 32'h08, 1, 32'h40, 0, 32'h0,    1, 0, 0, 32'h08, 32'h5A5A, 1, 0, 32'hA000_0002);
    vt[4]  = vt[3];
    vt[5]  = vt[3];
    vt[6]  = mk(0, 1, 32'h08, 1, 32'h40, 0, 32'h0,    0, 1, 0, 32'h40, 32'h0,    1, 0, 32'hA000_0002);
    vt[7]  = mk(0, 1, 32'h08, 1, 32'h40, 0, 32'h0,    0, 1, 0, 32'h40, 32'h0,    0, 1, 32'hDEAD_BEEF);
    vt[8]  = vt[7];
    vt[9]  = vt[7];
    vt[10] = mk(0, 1, 32'h08, 1, 32'h40, 0, 32'h0,    1, 0, 0, 32'h08, 32'h5A5A, 0, 1, 32'hDEAD_BEEF);
    vt[11] = mk(0, 0, 32'h08, 1, 32'h40, 0, 32'h0,    0, 1, 0, 32'h40, 32'h0,    1, 0, 32'hA000_0002);
    vt[12] = mk(0, 0, 32'h08, 0, 32'h40, 0, 32'h0,    0, 0, 0, 32'h0,  32'h0,    0, 1, 32'hDEAD_BEEF);
    vt[13] = mk(0, 1, 32'h08, 0, 32'h10, 1, 32'h1234, 1, 0, 0, 32'h08, 32'h5A5A, 0, 0, 32'h0);
    vt[14] = mk(0, 1, 32'h08, 1, 32'h10, 1, 32'h1234, 1, 0, 0, 32'h08, 32'h5A5A, 1, 0, 32'hA000_0002);
    vt[15] = vt[14];
    vt[16] = vt[14];
    vt[17] = mk(0, 1, 32'h08, 1, 32'h10, 1, 32'h1234, 0, 1, 1, 32'h10, 32'h1234, 1, 0, 32'hA000_0002);
    vt[18] = mk(0, 1, 32'h08, 0, 32'h10, 1, 32'h1234, 1, 0, 0, 32'h08, 32'h5A5A, 0, 0, 32'h0);
    vt[19] = mk(0, 0, 32'h08, 0, 32'h10, 0, 32'h0,    0, 0, 0, 32'h0,  32'h0,    1, 0, 32'hA000_0002);
    vt[20] = mk(0, 0, 32'h08, 1, 32'h10, 0, 32'h0,    0, 1, 0, 32'h10, 32'h0,    0, 0, 32'h0);
    vt[21] = mk(0, 0, 32'h08, 0, 32'h10, 0, 32'h0,    0, 0, 0, 32'h0,  32'h0,    0, 1, 32'h0000_1234);

    rst = 1'b1;
    m0_req = 1'b0; m0_addr = '0; m0_wr_ena = 1'b0; m0_wr_data = 32'h5A5A;
    m1_req = 1'b0; m1_addr = '0; m1_wr_ena = 1'b0; m1_wr_data = '0;

    for (int i = 0; i < 22; i++) begin
      next_cycle();
      rst = vt[i].rst;
      m0_req = vt[i].r0; m0_addr = vt[i].a0;
      m1_req = vt[i].r1; m1_addr = vt[i].a1; m1_wr_ena = vt[i].w1; m1_wr_data = vt[i].d1;
      @(negedge clk);
      check($sformatf("row%0d m0_gnt", i),      32'(m0_gnt),      32'(vt[i].g0));
      check($sformatf("row%0d m1_gnt", i),      32'(m1_gnt),      32'(vt[i].g1));
      check($sformatf("row%0d mem_wr_ena", i),  32'(mem_wr_ena),  32'(vt[i].we));
      check($sformatf("row%0d mem_addr", i),    mem_addr,         vt[i].addr);
      check($sformatf("row%0d mem_wr_data", i), mem_wr_data,      vt[i].wd);
      check($sformatf("row%0d m0_rd_valid", i), 32'(m0_rd_valid), 32'(vt[i].rv0));
      check($sformatf("row%0d m1_rd_valid", i), 32'(m1_rd_valid), 32'(vt[i].rv1));
      if (vt[i].rv0 || vt[i].rv1)
        check($sformatf("row%0d m_rd_data", i), m_rd_data, vt[i].rdata);
    end

    // Lone requester keeps the port well past MAX_BURST, then yields at once on contention
    for (int c = 0; c < 20; c++) begin
      next_cycle();
      m0_req = 1'b1; m0_addr = 32'h08; m1_req = 1'b0; m1_wr_ena = 1'b0;
      @(negedge clk);
      check($sformatf("hold c%0d m0_gnt", c), 32'(m0_gnt), 32'd1);
      check($sformatf("hold c%0d m1_gnt", c), 32'(m1_gnt), 32'd0);
    end
    next_cycle();
    m1_req = 1'b1; m1_addr = 32'h40;
    @(negedge clk);
    check("hold c20 m1_gnt", 32'(m1_gnt), 32'd1);
    check("hold c20 m0_gnt", 32'(m0_gnt), 32'd0);

    // Reset in the cycle after a granted read squashes its rd_valid and restores M0 priority
    next_cycle();
    m0_req = 1'b0; m1_req = 1'b0;
    @(negedge clk);
    check("rstrd idle gnt", 32'({m0_gnt, m1_gnt}), 32'd0);
    next_cycle();
    m0_req = 1'b1; m0_addr = 32'h08;
    @(negedge clk);
    check("rstrd read m0_gnt", 32'(m0_gnt), 32'd1);
    next_cycle();
    rst = 1'b1; m0_req = 1'b0;
    @(negedge clk);
    check("rstrd m0_rd_valid", 32'(m0_rd_valid), 32'd0);
    check("rstrd gnt", 32'({m0_gnt, m1_gnt}), 32'd0);
    check("rstrd mem_addr", mem_addr, 32'h0);
    next_cycle();
    rst = 1'b0; m0_req = 1'b1; m1_req = 1'b1;
    @(negedge clk);
    check("rstrd tie m0_gnt", 32'(m0_gnt), 32'd1);
    check("rstrd tie m1_gnt", 32'(m1_gnt), 32'd0);
    check("rstrd m0_rd_valid after", 32'(m0_rd_valid), 32'd0);

    next_cycle();
    m0_req = 1'b0; m1_req = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single von Neumann memory port between two requesters.
- Master 0 is the multicycle CPU (fetch and data traffic). Master 1 is a secondary agent, such as a program loader, debug port or display reader.
- Round-robin arbitration with a bounded burst hold, so master 0 can keep the port across multi-cycle fetch/load sequences without starving master 1.
- Sits between the CPU's mem_* outputs and the memory, and tags read data back to the granted master.

Parameters:
N, 32, data width
AW, 32, address width
MAX_BURST, 4, max consecutive cycles one master may hold the port while the other is requesting (legal range 1..15)

Ports:
clk  in  1  clock
rst  in  1  reset
m0_req  in  1  master 0 requests the port this cycle
m0_addr  in  AW  master 0 address
m0_wr_ena  in  1  master 0 write strobe (0 = read)
m0_wr_data  in  N  master 0 write data
m0_gnt  out  1  master 0 owns the port this cycle
m0_rd_valid  out  1  read data for master 0 is on m_rd_data this cycle
m1_req, m1_addr, m1_wr_ena, m1_wr_data, m1_gnt, m1_rd_valid  same as m0_* for master 1
m_rd_data  out  N  read data returned to masters; equals mem_rd_data
mem_addr  out  AW  memory address
mem_wr_data  out  N  memory write data
mem_wr_ena  out  1  memory write enable
mem_rd_data  in  N  memory read data, valid one cycle after address

Behaviour:
- Reset: rst is synchronous and active-high on clock clk.
  - While rst=1: m0_gnt=m1_gnt=0, mem_wr_ena=0, mem_addr=0, mem_wr_data=0.
  - Next-edge state: owner=NONE, last=M1 (so M0 wins the first tie), burst_cnt=0, m0_rd_valid=m1_rd_valid=0.
  - Reset mid-burst or mid-read drops the grant and squashes any pending rd_valid.
- Grant decision: combinational, same-cycle, in priority order:
  1. If owner=X, mX_req=1, and either the other master is idle or burst_cnt < MAX_BURST-1, then keep X.
  2. Otherwise, if both masters request, grant the master that is not `last`.
  3. Otherwise, if exactly one master requests, grant it.
  4. Otherwise, grant NONE.
- gnt outputs: mX_gnt = (decision == X); at most one is high; zero-cycle grant latency.
- Registered on each edge:
  - owner <= decision.
  - If decision != NONE: last <= decision.
  - burst_cnt <= (decision == owner && decision != NONE) ? min(burst_cnt+1, 15) : 0.
- Memory mux:
  - Decision X: mem_addr=mX_addr, mem_wr_data=mX_wr_data, mem_wr_ena=mX_wr_ena.
  - Decision NONE: mem_addr=0, mem_wr_data=0, mem_wr_ena=0.
- Read return:
  - mX_rd_valid <= mX_gnt & ~mX_wr_ena (registered, 1-cycle latency).
  - m_rd_data is combinational from mem_rd_data.
  - A write produces no rd_valid.
- A master that drops req releases the port in that same cycle; the other master may be granted in that cycle.
- A lone requester holds the port indefinitely; the burst limit only applies under contention.
- MAX_BURST=1 gives strict per-cycle alternation under continuous contention.
- Masters must hold addr/wr_ena/wr_data stable while req=1 and gnt=0. The arbiter does not buffer requests.
- Ungranted writes never reach memory.
- No combinational path from mem_rd_data to any gnt.

Test Plan:
- Reset: assert rst 2 cycles with m0_req=m1_req=1 -> both gnt=0, mem_wr_ena=0. First cycle after release -> m0_gnt=1 (last=M1 at reset).
- Lone read: m1_req=1, m1_addr=0x40, m1_wr_ena=0 for 1 cycle, memory holds 0xDEADBEEF at 0x40 -> m1_gnt=1 that cycle, mem_addr=0x40. Next cycle m1_rd_valid=1, m_rd_data=0xDEADBEEF, m0_rd_valid=0.
- Contention, MAX_BURST=4: both req held high from cycle 0 -> m0_gnt cycles 0-3, m1_gnt cycles 4-7, m0_gnt cycles 8-11. gnt is never high for both masters.
- Uncontended hold: m0_req high 20 cycles, m1_req=0 -> m0_gnt high all 20 cycles. Assert m1_req at cycle 20 while burst_cnt is saturated -> m1_gnt at cycle 20.
- Write masking: m1_req=1, m1_wr_ena=1, addr=0x10, data=0x1234 while m0 holds the grant -> mem_wr_ena=0 until m1_gnt=1. Then exactly one cycle with mem_wr_ena=1, mem_addr=0x10, mem_wr_data=0x1234. No m1_rd_valid afterward.
- Reset mid-read: m0 read granted at cycle 5, rst=1 at cycle 6 -> m0_rd_valid=0 at cycle 6, owner NONE after reset. Next tie after release goes to m0.
